mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk (rising edge), rst_n.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, accepts request
- req_op  in  3  LB=000 LH=001 LW=010 LBU=011 LHU=100 SB=101 SH=110 SW=111
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended
- resp_err  out  1  misaligned access flag
- mem_adress  out  32  word address to data_memory
- mem_write_data  out  32  word to data_memory
- mem_read  out  1  data_memory read strobe
- mem_write  out  1  data_memory write strobe
- mem_read_data  in  32  word from data_memory, valid the cycle after mem_read

Function
REQ-003 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-004 The FSM SHALL have states IDLE, LD_RD, LD_CAP, RMW_RD, RMW_MRG, WR, ERR.
REQ-005 On accept: LB/LH/LW/LBU/LHU -> LD_RD; SW -> WR; SB/SH -> RMW_RD; misaligned (when trapping) -> ERR.
REQ-006 LD_RD SHALL drive mem_read=1 for one cycle, then go to LD_CAP; LD_CAP SHALL register the extracted result, pulse resp_valid, and return to IDLE (load latency 2 cycles after accept).
REQ-007 WR SHALL drive mem_write=1 with the full word for one cycle, pulse resp_valid, and return to IDLE (SW latency 1 cycle).
REQ-008 RMW_RD SHALL drive mem_read=1; RMW_MRG SHALL merge the store lane into the captured word; WR SHALL then write it (SB/SH latency 3 cycles).
REQ-009 mem_adress SHALL be {2'b00, addr[31:2]} of the latched request address; word addressing is fixed.
REQ-010 Byte order SHALL be little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24; halfword addr[1]=0 selects bits 15:0.
REQ-011 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits; LW SHALL pass the word unchanged.
REQ-012 Sub-word stores SHALL modify only the addressed lane(s); all other bits SHALL keep the value read in RMW_RD.
REQ-013 mem_read and mem_write SHALL never be 1 in the same cycle; both SHALL be 0 in IDLE, RMW_MRG, LD_CAP and ERR.
REQ-014 resp_rdata SHALL hold its last value until the next load completes; stores SHALL not change it.
REQ-015 A req_valid asserted while req_ready=0 SHALL be ignored, with no queueing.
REQ-016 Request fields SHALL be latched at accept; input changes after accept SHALL have no effect.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE and set req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_adress=0 and mem_write_data=0.
REQ-018 A reset mid-operation SHALL drop the pending operation with no write issued; RMW merge data SHALL be discarded.

Configuration
REQ-019 With MEM_ACCESS_MISALIGN_TRAP_EN defined, LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]=1 SHALL go to ERR, perform no memory access, and pulse resp_valid with resp_err=1 in the next cycle, leaving resp_rdata unchanged.
REQ-020 Without the macro, misaligned addresses SHALL be aligned down (low bits forced to 0 for the access size), resp_err SHALL be tied 0 and ERR SHALL be absent.

Structure
REQ-021 Package mem_access_pkg SHALL hold the op encoding, the FSM state typedef and lane-width constants.
REQ-022 Sub-module load_align (combinational lane select plus extension) SHALL be instantiated once and reused by the RMW merge for lane selection.

Verification
REQ-023 With word 0 = 0x8899AABB: LB addr 3 -> resp_rdata 0xFFFFFF88 two cycles after accept; LBU addr 3 -> 0x00000088.
REQ-024 With word 0 = 0x8899AABB: LH addr 2 -> 0xFFFF8899; LHU addr 0 -> 0x0000AABB; LW addr 0 -> 0x8899AABB.
REQ-025 SB addr 5, wdata 0x000000EE, word 1 = 0x11223344 -> read, then one write of 0x1122EE44 to mem_adress 1 with resp_valid 3 cycles after accept.
REQ-026 SW addr 60, wdata 0x0000001F -> one mem_write cycle, mem_adress 15, mem_write_data 0x0000001F, no mem_read.
REQ-027 LW addr 2: with the macro -> resp_err=1 and no strobes; without it -> returns word 0.
REQ-028 rst_n pulsed low during RMW_MRG of SH -> mem_write is never asserted, word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_pkg: shared op encoding, FSM state constants, lane widths and
// helpers. Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_access_pkg;

  localparam int c_byte_w = 8;
  localparam int c_half_w = 16;
  localparam int c_word_w = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_ld_rd   = 3'd1;
  localparam logic [2:0] c_st_ld_cap  = 3'd2;
  localparam logic [2:0] c_st_rmw_rd  = 3'd3;
  localparam logic [2:0] c_st_rmw_mrg = 3'd4;
  localparam logic [2:0] c_st_wr      = 3'd5;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam logic [2:0] c_st_err     = 3'd6;
`endif

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    op_is_load = (op <= OP_LHU);
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] offset);
    case (op_size(op))
      SZ_WORD: op_misaligned = (offset != 2'b00);
      SZ_HALF: op_misaligned = offset[0];
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_align: little-endian lane select with sign/zero extension, plus the
// byte-lane mask of the addressed lane(s). Offsets are aligned down to size.
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_align
  import mem_access_pkg::*;
(
  input  logic [c_word_w-1:0] i_word,
  input  logic [1:0]          i_offset,
  input  size_t               i_size,
  input  logic                i_sign_ext,
  output logic [c_word_w-1:0] o_data,
  output logic [3:0]          o_lane_mask
);

  logic [1:0]          w_off;
  logic [c_byte_w-1:0] w_byte;
  logic [c_half_w-1:0] w_half;

  always_comb begin
    case (i_size)
      SZ_WORD: w_off = 2'b00;
      SZ_HALF: w_off = {i_offset[1], 1'b0};
      default: w_off = i_offset;
    endcase

    case (w_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = w_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SZ_BYTE: begin
        o_data      = {{(c_word_w - c_byte_w){i_sign_ext & w_byte[c_byte_w-1]}}, w_byte};
        o_lane_mask = 4'b0001 << w_off;
      end
      SZ_HALF: begin
        o_data      = {{(c_word_w - c_half_w){i_sign_ext & w_half[c_half_w-1]}}, w_half};
        o_lane_mask = w_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_data      = i_word;
        o_lane_mask = 4'b1111;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit: load/store sequencer to a word-addressed data memory with
// read-modify-write for sub-word stores. Optional feature macro:
// MEM_ACCESS_MISALIGN_TRAP_EN (trap misaligned accesses instead of aligning).
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_adress,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_wr_word;
  logic [31:0] r_rdata;
  logic        r_resp_valid;

  size_t       w_size;
  state_t      w_accept_state;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_rep;
  logic [31:0] w_merged;
  logic [3:0]  w_lane_mask;

  assign w_size = op_size(r_op);

  always_comb begin
    w_accept_state = c_st_rmw_rd;
    if (op_is_load(req_op)) begin
      w_accept_state = c_st_ld_rd;
    end else if (req_op == OP_SW) begin
      w_accept_state = c_st_wr;
    end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (op_misaligned(req_op, req_addr[1:0])) begin
      w_accept_state = c_st_err;
    end
`endif
  end

  // One aligner serves both the load result and the RMW lane mask.
  load_align u_load_align (
    .i_word      (mem_read_data),
    .i_offset    (r_addr[1:0]),
    .i_size      (w_size),
    .i_sign_ext  (op_signed(r_op)),
    .o_data      (w_ld_data),
    .o_lane_mask (w_lane_mask)
  );

  always_comb begin
    case (w_size)
      SZ_BYTE: w_st_rep = {4{r_wdata[7:0]}};
      SZ_HALF: w_st_rep = {2{r_wdata[15:0]}};
      default: w_st_rep = r_wdata;
    endcase
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_merged[i*c_byte_w +: c_byte_w] = w_lane_mask[i] ? w_st_rep[i*c_byte_w +: c_byte_w]
                                                                : mem_read_data[i*c_byte_w +: c_byte_w];
    end
  endgenerate

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic r_resp_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_err <= 1'b0;
    end else begin
      r_resp_err <= (r_state == c_st_err);
    end
  end
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_op         <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wr_word    <= 32'h0;
      r_rdata      <= 32'h0;
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (req_op == OP_SW) begin
              r_wr_word <= req_wdata;
            end
            r_state <= w_accept_state;
          end
        end
        c_st_ld_rd:   r_state <= c_st_ld_cap;
        c_st_ld_cap: begin
          r_rdata      <= w_ld_data;
          r_resp_valid <= 1'b1;
          r_state      <= c_st_idle;
        end
        c_st_rmw_rd:  r_state <= c_st_rmw_mrg;
        c_st_rmw_mrg: begin
          r_wr_word <= w_merged;
          r_state   <= c_st_wr;
        end
        c_st_wr: begin
          r_resp_valid <= 1'b1;
          r_state      <= c_st_idle;
        end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        c_st_err: begin
          r_resp_valid <= 1'b1;
          r_state      <= c_st_idle;
        end
`endif
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign req_ready      = (r_state == c_st_idle);
  assign mem_read       = (r_state == c_st_ld_rd) || (r_state == c_st_rmw_rd);
  assign mem_write      = (r_state == c_st_wr);
  assign mem_adress     = {2'b00, r_addr[31:2]};
  assign mem_write_data = r_wr_word;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_unit: random and directed requests against a transaction-level
// model of memory contents, response timing and strobe schedule.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int c_words = 64;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit c_trap = 1'b1;
`else
  localparam bit c_trap = 1'b0;
`endif
  localparam logic [2:0] c_op_lb = 3'b000, c_op_lh = 3'b001, c_op_lw = 3'b010, c_op_lbu = 3'b011;
  localparam logic [2:0] c_op_lhu = 3'b100, c_op_sb = 3'b101, c_op_sh = 3'b110, c_op_sw = 3'b111;

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_adress, mem_write_data;
  logic [31:0] mem_read_data = 32'h0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_adress(mem_adress), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [31:0] mem [c_words];
  logic [31:0] ref_mem [c_words];
  logic [31:0] cur_rdata;

  // outstanding transaction as predicted by the model
  bit          p_valid = 1'b0;
  int          p_acc = 0, p_done = 0, p_kind = 0, p_wa = 0;
  logic [31:0] p_rdata = 32'h0, p_word = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h8899AABB;
    if (i == 1) return 32'h11223344;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int sh;
    case (op)
      c_op_lb, c_op_lbu: begin
        sh = 8 * int'(a[1:0]);
        v  = (w >> sh) & 32'hFF;
        if (op == c_op_lb && v[7]) v = v | 32'hFFFFFF00;
      end
      c_op_lh, c_op_lhu: begin
        sh = 16 * int'(a[1]);
        v  = (w >> sh) & 32'hFFFF;
        if (op == c_op_lh && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    case (op)
      c_op_sb: begin
        sh = 8 * int'(a[1:0]);
        m  = 32'hFF << sh;
        return (w & ~m) | ((wd & 32'hFF) << sh);
      end
      c_op_sh: begin
        sh = 16 * int'(a[1]);
        m  = 32'hFFFF << sh;
        return (w & ~m) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == c_op_lw || op == c_op_sw) return a[1:0] != 2'b00;
    if (op == c_op_lh || op == c_op_lhu || op == c_op_sh) return a[0];
    return 1'b0;
  endfunction

  // data memory behind the DUT
  initial begin
    for (int i = 0; i < c_words; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_read)  mem_read_data <= mem[mem_adress[5:0]];
      if (mem_write) mem[mem_adress[5:0]] <= mem_write_data;
    end
  end

  // per-cycle comparison of all outputs against the model
  initial begin
    bit busy, rv, rd, wr;
    for (int i = 0; i < c_words; i++) ref_mem[i] = init_word(i);
    cur_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_rdata = 32'h0;
      end else begin
        busy = p_valid && (cyc < p_done);
        rv   = p_valid && (cyc == p_done);
        rd   = p_valid && (cyc == p_acc) && (p_kind == 0 || p_kind == 2);
        wr   = p_valid && ((p_kind == 1 && cyc == p_acc) || (p_kind == 2 && cyc == p_acc + 2));
        if (rv && p_kind == 0) cur_rdata = p_rdata;
        if (rv && (p_kind == 1 || p_kind == 2)) ref_mem[p_wa] = p_word;
        chk("req_ready", {31'h0, req_ready}, {31'h0, !busy});
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, rv});
        chk("resp_err", {31'h0, resp_err}, {31'h0, rv && p_kind == 3});
        chk("resp_rdata", resp_rdata, cur_rdata);
        chk("mem_read", {31'h0, mem_read}, {31'h0, rd});
        chk("mem_write", {31'h0, mem_write}, {31'h0, wr});
        if (rd || wr) chk("mem_adress", mem_adress, 32'(p_wa));
        if (wr) chk("mem_write_data", mem_write_data, p_word);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] o_rdata, output logic o_err, output int o_rd,
                        output int o_wr, output logic [31:0] o_wa, output logic [31:0] o_wd);
    int t, lat, kind;
    o_rdata = 32'h0; o_err = 1'b0; o_rd = 0; o_wr = 0; o_wa = 32'h0; o_wd = 32'h0;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    if (c_trap && misaligned(op, addr)) begin kind = 3; lat = 1; end
    else if (op <= c_op_lhu)             begin kind = 0; lat = 2; end
    else if (op == c_op_sw)              begin kind = 1; lat = 1; end
    else                                 begin kind = 2; lat = 3; end
    p_wa    = int'(addr[7:2]);
    p_rdata = model_load(ref_mem[p_wa], op, addr);
    p_word  = model_store(ref_mem[p_wa], op, addr, wdata);
    p_kind  = kind;
    p_acc   = cyc;
    p_done  = cyc + lat;
    p_valid = 1'b1;
    req_valid = 1'b0; req_op = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (mem_read) o_rd++;
      if (mem_write) begin o_wr++; o_wa = mem_adress; o_wd = mem_write_data; end
      if (cyc == p_done) begin o_rdata = resp_rdata; o_err = resp_err; end
      // requests raised while busy must be ignored
      if (cyc < p_done) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end while (cyc < p_done && t < 10);
    if (cyc != p_done) chk("resp_timeout", 32'(cyc), 32'(p_done));
  endtask

  task automatic reset_mid_sh();
    @(negedge clk);
    req_valid = 1'b1; req_op = c_op_sh; req_addr = 32'd6; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    p_wa = 1; p_kind = 2; p_rdata = 32'h0;
    p_word = model_store(ref_mem[1], c_op_sh, 32'd6, 32'h0000BEEF);
    p_acc = cyc; p_done = cyc + 3; p_valid = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    p_valid = 1'b0;
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_adress", mem_adress, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, wa, wd;
    logic        err;
    int          nr, nw;
    #12;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_resp_err", {31'h0, resp_err}, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_mem_read", {31'h0, mem_read}, 32'h0);
    chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
    chk("reset_mem_adress", mem_adress, 32'h0);
    chk("reset_mem_write_data", mem_write_data, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(c_op_lb, 32'd3, 32'h0, rdata, err, nr, nw, wa, wd);
    chk("lb_addr3", rdata, 32'hFFFFFF88);
    chk("lb_addr3_model", p_rdata, 32'hFFFFFF88);
    run_op(c_op_lbu, 32'd3, 32'h0, rdata, err, nr, nw, wa, wd);
    chk("lbu_addr3", rdata, 32'h00000088);
    run_op(c_op_lh, 32'd2, 32'h0, rdata, err, nr, nw, wa, wd);
    chk("lh_addr2", rdata, 32'hFFFF8899);
    chk("lh_addr2_model", p_rdata, 32'hFFFF8899);
    run_op(c_op_lhu, 32'd0, 32'h0, rdata, err, nr, nw, wa, wd);
    chk("lhu_addr0", rdata, 32'h0000AABB);
    run_op(c_op_lw, 32'd0, 32'h0, rdata, err, nr, nw, wa, wd);
    chk("lw_addr0", rdata, 32'h8899AABB);

    run_op(c_op_sb, 32'd5, 32'h000000EE, rdata, err, nr, nw, wa, wd);
    chk("sb_reads", 32'(nr), 32'd1);
    chk("sb_writes", 32'(nw), 32'd1);
    chk("sb_wr_addr", wa, 32'd1);
    chk("sb_wr_data", wd, 32'h1122EE44);
    chk("sb_model_word", p_word, 32'h1122EE44);

    run_op(c_op_sw, 32'd60, 32'h0000001F, rdata, err, nr, nw, wa, wd);
    chk("sw_reads", 32'(nr), 32'd0);
    chk("sw_writes", 32'(nw), 32'd1);
    chk("sw_wr_addr", wa, 32'd15);
    chk("sw_wr_data", wd, 32'h0000001F);

    run_op(c_op_lw, 32'd2, 32'h0, rdata, err, nr, nw, wa, wd);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'h0, err}, 32'h1);
    chk("lw_mis_strobes", 32'(nr + nw), 32'd0);
    chk("lw_mis_rdata_held", rdata, 32'h8899AABB);
`else
    chk("lw_mis_err", {31'h0, err}, 32'h0);
    chk("lw_mis_rdata", rdata, 32'h8899AABB);
`endif

    reset_mid_sh();
    chk("rmw_reset_word", mem[1], 32'h1122EE44);
    @(negedge clk);
    chk("rmw_reset_ready", {31'h0, req_ready}, 32'h1);

    for (int n = 0; n < 300; n++) begin
      run_op(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
             rdata, err, nr, nw, wa, wd);
    end

    @(negedge clk);
    for (int i = 0; i < c_words; i++) chk("final_mem_word", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
